// File: rtl/eeg_load_ctrl_pkg.sv
// Shared types, memory map and fixed-point constants for the EEG input loader.
// The sample conversion helper lives here so every consumer centres ADC codes identically.
package Defines;

    localparam int ADC_WIDTH            = 16;
    localparam int NUM_PATCHES          = 60;
    localparam int PATCH_LEN            = 64;
    localparam int Q_STO_INT_RES_DOUBLE = 20;
    localparam int INT_RES_DOUBLE_WIDTH = 30;

    typedef logic [ADC_WIDTH-1:0]            AdcData_t;
    typedef logic [15:0]                     IntResAddr_t;
    typedef logic [INT_RES_DOUBLE_WIDTH-1:0] IntResDouble_t;

    typedef enum logic {
        SINGLE_WIDTH,
        DOUBLE_WIDTH
    } DataWidth_t;

    typedef enum logic [1:0] {
        INT_RES_SW_FX,
        INT_RES_DW_FX,
        INT_RES_SQRT_FX
    } FxFormatIntRes_t;

    typedef enum logic [1:0] {
        EEG_INPUT_MEM,
        PATCH_MEM,
        CLASS_MEM
    } MemRegion_t;

    localparam int NUM_MEM_REGIONS = 3;
    localparam IntResAddr_t mem_map [NUM_MEM_REGIONS] = '{16'd0, 16'd3840, 16'd7680};

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SAMPLE,
        WRITE,
        DONE
    } EegLoadState_t;

    typedef enum logic {
        POSEDGE_TRIGGERED,
        LEVEL_TRIGGERED
    } CounterMode_t;

    // ADC codes are offset-binary; flipping the MSB gives two's complement with the
    // binary point at bit 16, which is then aligned to the 20 fractional bits of storage.
    localparam int ADC_TO_INT_RES_SHIFT = Q_STO_INT_RES_DOUBLE - ADC_WIDTH;

    function automatic IntResDouble_t adc_to_int_res(input AdcData_t sample);
        logic signed [ADC_WIDTH-1:0]            centered;
        logic signed [INT_RES_DOUBLE_WIDTH-1:0] extended;
        centered = {~sample[ADC_WIDTH-1], sample[ADC_WIDTH-2:0]};
        extended = {{(INT_RES_DOUBLE_WIDTH-ADC_WIDTH){centered[ADC_WIDTH-1]}}, centered};
        return IntResDouble_t'(extended <<< ADC_TO_INT_RES_SHIFT);
    endfunction

endpackage

// File: rtl/eeg_load_ctrl_counter.sv
// General-purpose up-counter with synchronous clear; in POSEDGE_TRIGGERED mode it
// advances once per rising edge of trig, in LEVEL_TRIGGERED mode on every high cycle.
module counter
    import Defines::*;
#(
    parameter int           WIDTH = 16,
    parameter CounterMode_t MODE  = POSEDGE_TRIGGERED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             trig,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             trig_prev_q;
    logic             trig_prev_d;
    logic             step;

    always_comb begin
        step        = 1'b0;
        count_d     = count_q;
        trig_prev_d = trig;

        if (MODE == POSEDGE_TRIGGERED) begin
            step = trig && !trig_prev_q;
        end else begin
            step = trig;
        end

        if (clear) begin
            count_d     = '0;
            trig_prev_d = 1'b0;
        end else if (step) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            trig_prev_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            trig_prev_q <= trig_prev_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/eeg_load_ctrl.sv
// Streams one inference window of ADC samples into int-res memory, converting each
// sample to the double-width fixed-point format and handshaking on mem_ready.
//
// state       | meaning
// IDLE        | waiting for start; strobes ignored
// WAIT_SAMPLE | window open, waiting for the next new_sample strobe
// WRITE       | converted sample registered, wr_en held until mem_ready
// DONE        | last sample accepted; done pulses for one cycle
module eeg_load_ctrl
    import Defines::*;
#(
    parameter int          NUM_SAMPLES = NUM_PATCHES * PATCH_LEN,
    parameter IntResAddr_t BASE_ADDR   = mem_map[EEG_INPUT_MEM]
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            new_sample,
    input  AdcData_t        adc_data,
    input  logic            mem_ready,
    output logic            wr_en,
    output IntResAddr_t     wr_addr,
    output IntResDouble_t   wr_data,
    output DataWidth_t      wr_width,
    output FxFormatIntRes_t wr_format,
    output logic            busy,
    output logic            done,
    output logic            overflow
);

    localparam int IDX_W = $bits(IntResAddr_t);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);

    EegLoadState_t state_q;
    EegLoadState_t state_d;
    logic          wr_en_q;
    logic          wr_en_d;
    IntResAddr_t   wr_addr_q;
    IntResAddr_t   wr_addr_d;
    IntResDouble_t wr_data_q;
    IntResDouble_t wr_data_d;
    logic          busy_q;
    logic          busy_d;
    logic          done_q;
    logic          done_d;
    logic          overflow_q;
    logic          overflow_d;

    logic             start_accept;
    logic             wr_accept;
    logic             last_write;
    logic [IDX_W-1:0] sample_idx;

    // The index only advances on accepted writes, so it always names the slot of the
    // next sample to be captured; it tops out at NUM_SAMPLES and is cleared by start.
    counter #(
        .WIDTH (IDX_W),
        .MODE  (POSEDGE_TRIGGERED)
    ) u_sample_idx (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_accept),
        .trig  (wr_accept),
        .count (sample_idx)
    );

    always_comb begin
        start_accept = start && (state_q == IDLE);
        wr_accept    = wr_en_q && mem_ready && (state_q == WRITE);
        last_write   = (sample_idx == LAST_IDX);

        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (start_accept) begin
                    state_d    = WAIT_SAMPLE;
                    overflow_d = 1'b0;
                end
            end
            WAIT_SAMPLE: begin
                if (new_sample) begin
                    state_d   = WRITE;
                    wr_addr_d = BASE_ADDR + sample_idx;
                    wr_data_d = adc_to_int_res(adc_data);
                end
            end
            WRITE: begin
                if (new_sample) begin
                    overflow_d = 1'b1;
                end
                if (wr_accept) begin
                    state_d = last_write ? DONE : WAIT_SAMPLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        wr_en_d = (state_d == WRITE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= BASE_ADDR;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign wr_width  = DOUBLE_WIDTH;
    assign wr_format = INT_RES_DW_FX;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/eeg_load_ctrl.md
EEG_LOAD_CTRL -- requirements
Module: eeg_load_ctrl

Interface
REQ-001 SHALL have parameter NUM_SAMPLES, default NUM_PATCHES*PATCH_LEN (3840): the number of ADC samples per inference window.
REQ-002 SHALL have parameter BASE_ADDR, default mem_map[EEG_INPUT_MEM] (0): the intermediate-result address of the first sample.
REQ-003 SHALL use one clock and an asynchronous active-low reset: clk  in  1  system clock; rst_n  in  1  async reset, active-low.
REQ-004 start  in  1  pulse that begins a load; honoured only in IDLE.
REQ-005 new_sample  in  1  one-cycle strobe marking adc_data valid.
REQ-006 adc_data  in  AdcData_t (16)  unsigned ADC sample.
REQ-007 mem_ready  in  1  int-res memory accepts the write this cycle.
REQ-008 wr_en  out  1  write request to int-res memory.
REQ-009 wr_addr  out  IntResAddr_t (16)  write address.
REQ-010 wr_data  out  IntResDouble_t (30)  converted sample.
REQ-011 wr_width  out  DataWidth_t  held at DOUBLE_WIDTH.
REQ-012 wr_format  out  FxFormatIntRes_t  held at INT_RES_DW_FX.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse after the last write is accepted.
REQ-015 overflow  out  1  sticky flag: a sample was lost.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT_SAMPLE, WRITE, DONE.
- IDLE->WAIT_SAMPLE on start.
- WAIT_SAMPLE->WRITE on new_sample.
- WRITE->WAIT_SAMPLE on an accepted write (wr_en && mem_ready) when fewer than NUM_SAMPLES writes have been accepted.
- WRITE->DONE on the accepted write that is number NUM_SAMPLES.
- DONE->IDLE unconditionally after 1 cycle.
REQ-017 SHALL convert each sample combinationally before registering it:
- centered = adc_data with bit 15 inverted, read as signed 16b (range -32768..32767).
- wr_data = sign-extend(centered) to 30b, then shift left 4 (Q_STO_INT_RES_DOUBLE = 20 fractional bits; value = centered/2^16).
REQ-018 SHALL register wr_data and wr_addr on the new_sample cycle and assert wr_en in the following cycle (latency 1).
REQ-019 SHALL hold wr_en, wr_addr and wr_data stable until mem_ready is seen high while wr_en is high.
REQ-020 SHALL set wr_addr = BASE_ADDR + sample index, where the index runs 0..NUM_SAMPLES-1.
REQ-021 SHALL increment the index only on an accepted write; the index SHALL never wrap within one load.
REQ-022 SHALL set overflow on new_sample while in WRITE; the pending sample is kept and the new one is dropped.
REQ-023 SHALL ignore new_sample in IDLE and DONE without setting overflow.
REQ-024 SHALL ignore start outside IDLE.
REQ-025 SHALL clear overflow and the index on an accepted start.
REQ-026 SHALL assert done in the DONE state only.
REQ-027 SHALL treat start and new_sample in the same IDLE cycle as start only; that sample is not captured.

Reset
REQ-028 SHALL on rst_n low, regardless of clk:
- enter IDLE;
- drive wr_en, busy, done and overflow to 0;
- drive wr_addr to BASE_ADDR and wr_data to 0;
- set the index to 0.
REQ-029 SHALL abandon a pending write when reset is asserted mid-load, with no write issued after reset is released.

Structure
REQ-030 SHALL take AdcData_t, IntResAddr_t, IntResDouble_t, DataWidth_t, FxFormatIntRes_t, mem_map, EEG_INPUT_MEM, NUM_PATCHES, PATCH_LEN and Q_STO_INT_RES_DOUBLE from package Defines.
REQ-031 SHALL add the FSM state enum EegLoadState_t to Defines.
REQ-032 SHALL instantiate the existing counter sub-module in POSEDGE_TRIGGERED mode for the sample index; no other sub-module is required.

Verification
REQ-033 Bench SHALL cover these directed scenarios:
- Conversion: start, then adc_data 0x8000 / 0x0000 / 0xFFFF with mem_ready=1 -> wr_data 0 / 0x3FF80000 / 0x0007FFF0 at wr_addr 0 / 1 / 2, each one cycle after its strobe.
- Full window: 3840 strobes with mem_ready=1 -> 3840 writes at addresses 0..3839, done high for exactly 1 cycle after the last write, busy low afterwards, no write at 3840.
- Back-pressure: mem_ready=0 for 5 cycles on sample 10 -> wr_en, wr_addr (10) and wr_data held constant; write accepted on the first cycle with mem_ready=1.
- Overflow: second strobe while sample 10 is pending -> overflow=1, sample 10 written, dropped value never written; next start clears overflow.
- Reset mid-load: rst_n low at index 100 -> all outputs at reset values immediately (asynchronously); after release, strobes are ignored until start, and the next load begins at address 0.
- start while busy and new_sample in IDLE -> no state or index change, no write.
